// File: rtl/rx_rs_framer.sv
// Receive RS block framer: finds SOF K-characters and tags RS_K data bytes plus RS_N-RS_K check bytes per codeword.
// Latency: 1 cycle from input byte to o_enc_data and its tags; all outputs registered.
// No backpressure: an invalid byte inside a block aborts it. Optional loss-of-sync detection: RX_RS_FRAMER_LOS_DET_EN.
module rx_rs_framer #(
  parameter int         RS_N       = 255,
  parameter int         RS_K       = 239,
  parameter logic [7:0] SOF_K      = 8'hFB,
  parameter int         LOS_THRESH = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_data_aligned,
  input  logic [7:0]  i_data,
  input  logic        i_is_k,
  input  logic        i_data_valid,
  output logic [7:0]  o_enc_data,
  output logic        o_sof,
  output logic        o_rs_data_symbol,
  output logic        o_rs_check_symbol,
  output logic        o_kchar_err,
  output logic        o_blk_abort,
  output logic [15:0] o_blk_cnt,
  output logic        o_los
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [7:0] DATA_LAST  = 8'(RS_K - 1);
  localparam logic [7:0] CHECK_LAST = 8'(RS_N - RS_K - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  enc_data_q, enc_data_d;
  logic        sof_q, sof_d;
  logic        dsym_q, dsym_d;
  logic        csym_q, csym_d;
  logic        kerr_q, kerr_d;
  logic        abort_q, abort_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        blk_done;
  logic        sof_allow;
  logic        sof_hit;

  assign sof_hit = i_data_valid & i_is_k & (i_data == SOF_K) & sof_allow;

  // Framing FSM: next state, byte counter and the tags for the byte being forwarded
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enc_data_d = enc_data_q;
    sof_d      = 1'b0;
    dsym_d     = 1'b0;
    csym_d     = 1'b0;
    kerr_d     = 1'b0;
    abort_d    = 1'b0;
    blk_cnt_d  = blk_cnt_q;
    blk_done   = 1'b0;
    if (!i_data_aligned) begin
      // Lost alignment overrides everything; only an open block counts as aborted.
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      abort_d = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sof_hit) begin
            state_d = ST_DATA;
            cnt_d   = 8'd0;
          end
        end
        ST_DATA, ST_CHECK: begin
          if (!i_data_valid) begin
            abort_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            enc_data_d = i_data;
            kerr_d     = i_is_k;
            if (state_q == ST_DATA) begin
              dsym_d = 1'b1;
              sof_d  = (cnt_q == 8'd0);
              if (cnt_q == DATA_LAST) begin
                state_d = ST_CHECK;
                cnt_d   = 8'd0;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              csym_d = 1'b1;
              if (cnt_q == CHECK_LAST) begin
                state_d   = ST_IDLE;
                cnt_d     = 8'd0;
                blk_cnt_d = blk_cnt_q + 16'd1;
                blk_done  = 1'b1;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Framing registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      enc_data_q <= 8'd0;
      sof_q      <= 1'b0;
      dsym_q     <= 1'b0;
      csym_q     <= 1'b0;
      kerr_q     <= 1'b0;
      abort_q    <= 1'b0;
      blk_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enc_data_q <= enc_data_d;
      sof_q      <= sof_d;
      dsym_q     <= dsym_d;
      csym_q     <= csym_d;
      kerr_q     <= kerr_d;
      abort_q    <= abort_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

`ifdef RX_RS_FRAMER_LOS_DET_EN
  logic [1:0] err_blk_q, err_blk_d;
  logic       blk_kerr_q, blk_kerr_d;
  logic [2:0] holdoff_q, holdoff_d;
  logic       los_q, los_d;

  assign sof_allow = (holdoff_q == 3'd0);

  // Errored-block tracking, loss-of-sync pulse and post-LOS SOF holdoff
  always_comb begin
    err_blk_d  = err_blk_q;
    los_d      = 1'b0;
    holdoff_d  = holdoff_q - 3'(holdoff_q != 3'd0);
    blk_kerr_d = (state_q == ST_IDLE) ? 1'b0 : (blk_kerr_q | kerr_d);
    if (!i_data_aligned) begin
      err_blk_d  = 2'd0;
      blk_kerr_d = 1'b0;
    end else if (blk_done) begin
      if (blk_kerr_q | kerr_d) begin
        if (err_blk_q == 2'(LOS_THRESH - 1)) begin
          los_d     = 1'b1;
          err_blk_d = 2'd0;
          // Gives the decoder time to reset before the next block is accepted.
          holdoff_d = 3'd4;
        end else begin
          err_blk_d = err_blk_q + 2'd1;
        end
      end else begin
        err_blk_d = 2'd0;
      end
    end
  end

  // Loss-of-sync registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_blk_q  <= 2'd0;
      blk_kerr_q <= 1'b0;
      holdoff_q  <= 3'd0;
      los_q      <= 1'b0;
    end else begin
      err_blk_q  <= err_blk_d;
      blk_kerr_q <= blk_kerr_d;
      holdoff_q  <= holdoff_d;
      los_q      <= los_d;
    end
  end

  assign o_los = los_q;
`else
  logic unused_ok;

  assign sof_allow = 1'b1;
  assign o_los     = 1'b0;
  // Keeps the block-end strobe and threshold referenced when LOS detection is compiled out.
  assign unused_ok = blk_done ^ (LOS_THRESH != 0);
`endif

  assign o_enc_data        = enc_data_q;
  assign o_sof             = sof_q;
  assign o_rs_data_symbol  = dsym_q;
  assign o_rs_check_symbol = csym_q;
  assign o_kchar_err       = kerr_q;
  assign o_blk_abort       = abort_q;
  assign o_blk_cnt         = blk_cnt_q;

endmodule

// File: tb/tb_rx_rs_framer.sv
// Bench for rx_rs_framer: table vectors, directed block sequences and a random stream against a codeword-position model.
module tb_rx_rs_framer;

  localparam int         RS_N       = 255;
  localparam int         RS_K       = 239;
  localparam logic [7:0] SOF_K      = 8'hFB;
  localparam int         LOS_THRESH = 3;
`ifdef RX_RS_FRAMER_LOS_DET_EN
  localparam bit LOS_EN = 1'b1;
`else
  localparam bit LOS_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_data_aligned;
  logic [7:0]  i_data;
  logic        i_is_k;
  logic        i_data_valid;
  logic [7:0]  o_enc_data;
  logic        o_sof;
  logic        o_rs_data_symbol;
  logic        o_rs_check_symbol;
  logic        o_kchar_err;
  logic        o_blk_abort;
  logic [15:0] o_blk_cnt;
  logic        o_los;

  rx_rs_framer #(
    .RS_N(RS_N), .RS_K(RS_K), .SOF_K(SOF_K), .LOS_THRESH(LOS_THRESH)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_aligned(i_data_aligned),
    .i_data(i_data), .i_is_k(i_is_k), .i_data_valid(i_data_valid),
    .o_enc_data(o_enc_data), .o_sof(o_sof), .o_rs_data_symbol(o_rs_data_symbol),
    .o_rs_check_symbol(o_rs_check_symbol), .o_kchar_err(o_kchar_err),
    .o_blk_abort(o_blk_abort), .o_blk_cnt(o_blk_cnt), .o_los(o_los)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: position within the codeword (-1 = between blocks), plus block-level LOS bookkeeping.
  int         m_pos  = -1;
  int         m_blk  = 0;
  logic [7:0] m_enc  = 8'h00;
  int         m_hold = 0;
  int         m_err  = 0;
  bit         m_bk   = 0;
  bit e_sof, e_d, e_c, e_k, e_ab, e_los;

  task automatic model(input logic al, input logic v, input logic k, input logic [7:0] d);
    int hold_now;
    hold_now = m_hold;
    if (m_hold > 0) m_hold--;
    {e_sof, e_d, e_c, e_k, e_ab, e_los} = '0;
    if (!al) begin
      e_ab  = (m_pos >= 0);
      m_pos = -1;
      m_err = 0;
    end else if (m_pos < 0) begin
      if (v && k && d == SOF_K && !(LOS_EN && hold_now > 0)) begin
        m_pos = 0;
        m_bk  = 0;
      end
    end else if (!v) begin
      e_ab  = 1;
      m_pos = -1;
    end else begin
      m_enc = d;
      e_sof = (m_pos == 0);
      e_d   = (m_pos < RS_K);
      e_c   = !e_d;
      e_k   = k;
      if (k) m_bk = 1;
      m_pos++;
      if (m_pos == RS_N) begin
        m_pos = -1;
        m_blk = (m_blk + 1) % 65536;
        if (LOS_EN) begin
          if (m_bk) begin
            m_err++;
            if (m_err == LOS_THRESH) begin
              e_los  = 1;
              m_err  = 0;
              m_hold = 4;
            end
          end else begin
            m_err = 0;
          end
        end
      end
    end
  endtask

  // Observed pulse tallies, cleared by the directed tests.
  int cyc = 0;
  int n_sof, n_d, n_c, n_k, n_ab, n_los, first_sof, last_sof;

  task automatic clear_tally();
    n_sof = 0; n_d = 0; n_c = 0; n_k = 0; n_ab = 0; n_los = 0;
    first_sof = -1; last_sof = -1;
  endtask

  // One byte cycle: drive, advance the model, sample 1 ns after the edge and compare every output.
  task automatic step(input logic al, input logic v, input logic k, input logic [7:0] d);
    i_data_aligned = al;
    i_data_valid   = v;
    i_is_k         = k;
    i_data         = d;
    model(al, v, k, d);
    @(posedge i_clk);
    #1;
    cyc++;
    check($sformatf("cycle %0d outputs", cyc),
          {2'b00, o_enc_data, o_sof, o_rs_data_symbol, o_rs_check_symbol, o_kchar_err,
           o_blk_abort, o_blk_cnt, o_los},
          {2'b00, m_enc, e_sof, e_d, e_c, e_k, e_ab, 16'(m_blk), e_los});
    if (o_sof) begin
      if (first_sof < 0) first_sof = cyc;
      last_sof = cyc;
      n_sof++;
    end
    if (o_rs_data_symbol)  n_d++;
    if (o_rs_check_symbol) n_c++;
    if (o_kchar_err)       n_k++;
    if (o_blk_abort)       n_ab++;
    if (o_los)             n_los++;
  endtask

  // SOF then a codeword; kpos injects K28.5 at that codeword index, abort_at drops valid there.
  task automatic send_block(input int kpos, input int abort_at);
    step(1, 1, 1, SOF_K);
    for (int i = 0; i < RS_N; i++) begin
      if (i == abort_at) begin
        step(1, 0, 0, 8'h00);
        return;
      end
      if (i == kpos) step(1, 1, 1, 8'hBC);
      else           step(1, 1, 0, 8'($urandom));
    end
  endtask

  typedef struct {
    logic       al, v, k;
    logic [7:0] d;
    logic [7:0] enc;
    logic [4:0] flags;  // {sof, data, check, kerr, abort}
  } vec_t;

  vec_t tbl[14];
  int   sof_cyc;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'hFB, 8'h00, 5'b00000};  // SOF while unaligned
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hFB, 8'h00, 5'b00000};  // FB as plain data
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'hFB, 8'h00, 5'b00000};  // SOF not valid
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 8'h00, 5'b00000};  // other K code in idle
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'hFB, 8'h00, 5'b00000};  // SOF accepted, not forwarded
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h11, 8'h11, 5'b11000};  // first data byte
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h22, 5'b01000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 8'hBC, 5'b01010};  // K inside block
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'hBC, 5'b00001};  // valid drop aborts, data holds
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h44, 8'hBC, 5'b00000};  // idle fill
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'hFB, 8'hBC, 5'b00000};  // SOF
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h55, 5'b11000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h66, 8'h55, 5'b00001};  // alignment loss aborts, K not reported
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'hFB, 8'h55, 5'b00000};

    i_rst_n = 1'b0;
    i_data_aligned = 1'b0; i_data_valid = 1'b0; i_is_k = 1'b0; i_data = 8'h00;
    clear_tally();
    repeat (3) @(posedge i_clk);
    #1;
    check("reset outputs",
          {2'b00, o_enc_data, o_sof, o_rs_data_symbol, o_rs_check_symbol, o_kchar_err,
           o_blk_abort, o_blk_cnt, o_los}, 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].al, tbl[i].v, tbl[i].k, tbl[i].d);
      check($sformatf("table row %0d", i),
            {19'd0, o_enc_data, o_sof, o_rs_data_symbol, o_rs_check_symbol, o_kchar_err, o_blk_abort},
            {19'd0, tbl[i].enc, tbl[i].flags});
    end

    // Single full block
    step(1, 1, 0, 8'h00);
    clear_tally();
    sof_cyc = cyc;
    send_block(-1, -1);
    step(1, 1, 0, 8'h00);
    check("full sof count", n_sof, 1);
    check("full sof latency", first_sof - sof_cyc, 2);
    check("full data tags", n_d, RS_K);
    check("full check tags", n_c, RS_N - RS_K);
    check("full blk_cnt", o_blk_cnt, 1);

    // Back-to-back blocks: SOF byte sits between codewords, so starts are RS_N+1 apart
    clear_tally();
    send_block(-1, -1);
    send_block(-1, -1);
    step(1, 1, 0, 8'h00);
    check("b2b sof count", n_sof, 2);
    check("b2b sof spacing", last_sof - first_sof, RS_N + 1);
    check("b2b data tags", n_d, 2 * RS_K);
    check("b2b blk_cnt", o_blk_cnt, 3);

    // Valid drop at data byte 100, then a full block
    clear_tally();
    send_block(-1, 100);
    check("abort pulse", n_ab, 1);
    check("abort blk_cnt", o_blk_cnt, 3);
    send_block(-1, -1);
    check("post-abort data tags", n_d, 100 + RS_K);
    check("post-abort blk_cnt", o_blk_cnt, 4);

    // K28.5 at check byte 5
    clear_tally();
    send_block(RS_K + 5, -1);
    check("kerr pulses", n_k, 1);
    check("kerr check tags", n_c, RS_N - RS_K);
    check("kerr blk_cnt", o_blk_cnt, 5);

    // Alignment dropped mid-CHECK; SOFs while unaligned are ignored
    send_block(-1, -1);
    step(1, 1, 1, SOF_K);
    for (int i = 0; i < RS_K + 8; i++) step(1, 1, 0, 8'($urandom));
    clear_tally();
    step(0, 1, 0, 8'h77);
    check("unalign abort", n_ab, 1);
    check("unalign flags", {o_rs_data_symbol, o_rs_check_symbol}, 0);
    step(0, 1, 1, SOF_K);
    step(0, 1, 0, 8'h01);
    step(0, 1, 1, SOF_K);
    step(1, 1, 0, 8'h02);
    check("unaligned sof ignored", n_sof + n_d + n_c, 0);
    check("unalign blk_cnt", o_blk_cnt, 6);

`ifdef RX_RS_FRAMER_LOS_DET_EN
    // Three K-errored blocks declare LOS; SOF at +2 ignored, SOF at +5 accepted
    clear_tally();
    for (int b = 0; b < 3; b++) send_block(10 + b, -1);
    check("los pulse", n_los, 1);
    step(1, 1, 0, 8'h00);
    step(1, 1, 1, SOF_K);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(1, 1, 1, SOF_K);
    step(1, 1, 0, 8'h5A);
    check("los holdoff sofs", n_sof, 4);
    step(1, 0, 0, 8'h00);
`endif

    // Random stream against the model
    for (int i = 0; i < 6000; i++) begin
      logic al, v, k;
      logic [7:0] d;
      al = ($urandom_range(0, 599) != 0);
      v  = ($urandom_range(0, 399) != 0);
      d  = 8'($urandom);
      k  = 1'b0;
      if (m_pos < 0) begin
        if ($urandom_range(0, 3) == 0) begin
          k = 1'b1;
          d = SOF_K;
        end
      end else if ($urandom_range(0, 149) == 0) begin
        k = 1'b1;
      end
      step(al, v, k, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
